multicycle_ctrl: RTL and testbench

Control unit for the RIUSJB multi-cycle CPU. A Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath write-enable and mux select, and exports its state on `ST` for the board LEDs. It also counts retired instructions for the display path.

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ctrl_out_dec.sv | 75 +++++++
 rtl/multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states,
// ALU operation constants and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_IF      = 4'd1,
    ST_ID      = 4'd2,
    ST_EX_R    = 4'd3,
    ST_EX_I    = 4'd4,
    ST_WB_ALU  = 4'd5,
    ST_LUI     = 4'd6,
    ST_MEM_ADR = 4'd7,
    ST_LW_MEM  = 4'd8,
    ST_WB_LW   = 4'd9,
    ST_SW_MEM  = 4'd10,
    ST_BEQ     = 4'd11,
    ST_JAL     = 4'd12,
    ST_JALR    = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_IMM = 2'b01;
  localparam logic [1:0] WD_MDR = 2'b10;
  localparam logic [1:0] WD_PC  = 2'b11;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_ALU = 2'b10;

endpackage

// File: rtl/ctrl_out_dec.sv
// Moore output decoder: maps the current control state to every datapath
// enable and select. Illegal states decode to all-zero outputs.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       zf,
  output logic       pc_write,
  output logic       pc0_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       rs2_imm_s,
  output logic [1:0] w_data_s,
  output logic [1:0] pc_s,
  output logic [3:0] alu_op
);

  always_comb begin
    pc_write  = 1'b0;
    pc0_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    rs2_imm_s = 1'b0;
    w_data_s  = WD_ALU;
    pc_s      = PCS_SEQ;
    alu_op    = ALU_ADD;
    case (state)
      ST_IF: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc0_write = 1'b1;
      end
      ST_EX_R: alu_op = op;
      ST_EX_I: begin
        rs2_imm_s = 1'b1;
        alu_op    = op;
      end
      ST_WB_ALU: reg_write = 1'b1;
      ST_LUI: begin
        reg_write = 1'b1;
        w_data_s  = WD_IMM;
      end
      ST_MEM_ADR: rs2_imm_s = 1'b1;
      ST_WB_LW: begin
        reg_write = 1'b1;
        w_data_s  = WD_MDR;
      end
      ST_SW_MEM: mem_write = 1'b1;
      // Branch taken when the SUB result is zero
      ST_BEQ: begin
        alu_op   = ALU_SUB;
        pc_s     = PCS_BR;
        pc_write = zf;
      end
      ST_JAL: begin
        reg_write = 1'b1;
        w_data_s  = WD_PC;
        pc_write  = 1'b1;
        pc_s      = PCS_BR;
      end
      ST_JALR: begin
        rs2_imm_s = 1'b1;
        reg_write = 1'b1;
        w_data_s  = WD_PC;
        pc_write  = 1'b1;
        pc_s      = PCS_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM with retired-instruction counter.
// Optional single-step mode: define MULTICYCLE_CTRL_STEP_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int W_CNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IS_R,
  input  logic             IS_IMM,
  input  logic             IS_LUI,
  input  logic             IS_LW,
  input  logic             IS_SW,
  input  logic             IS_BEQ,
  input  logic             IS_JAL,
  input  logic             IS_JALR,
  input  logic [3:0]       OP,
  input  logic [3:0]       FR,
`ifdef MULTICYCLE_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             PC_Write,
  output logic             PC0_Write,
  output logic             IR_Write,
  output logic             Reg_Write,
  output logic             Mem_Write,
  output logic             rs2_imm_s,
  output logic [1:0]       w_data_s,
  output logic [1:0]       PC_s,
  output logic [3:0]       ALU_OP,
  output logic [3:0]       ST,
  output logic [W_CNT-1:0] retire_cnt
);

`ifdef MULTICYCLE_CTRL_STEP_EN
  localparam state_t DONE_NEXT = ST_IDLE;
`else
  localparam state_t DONE_NEXT = ST_IF;
`endif

  state_t state;
  state_t state_next;
  logic   done;

  // Only ZF steers control; the other flags belong to the datapath
  logic   unused_flags;
  assign unused_flags = ^FR[2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      if (done) retire_cnt <= retire_cnt + W_CNT'(1);
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    done       = 1'b0;
    case (state)
`ifdef MULTICYCLE_CTRL_STEP_EN
      ST_IDLE: state_next = step ? ST_IF : ST_IDLE;
`else
      ST_IDLE: state_next = ST_IF;
`endif
      ST_IF: state_next = ST_ID;
      ST_ID: begin
        if (IS_R)                state_next = ST_EX_R;
        else if (IS_IMM)         state_next = ST_EX_I;
        else if (IS_LUI)         state_next = ST_LUI;
        else if (IS_LW || IS_SW) state_next = ST_MEM_ADR;
        else if (IS_BEQ)         state_next = ST_BEQ;
        else if (IS_JAL)         state_next = ST_JAL;
        else if (IS_JALR)        state_next = ST_JALR;
        else begin
          state_next = DONE_NEXT;
          done       = 1'b1;
        end
      end
      ST_EX_R, ST_EX_I: state_next = ST_WB_ALU;
      ST_MEM_ADR:       state_next = IS_LW ? ST_LW_MEM : ST_SW_MEM;
      ST_LW_MEM:        state_next = ST_WB_LW;
      ST_WB_ALU, ST_LUI, ST_WB_LW, ST_SW_MEM, ST_BEQ, ST_JAL, ST_JALR: begin
        state_next = DONE_NEXT;
        done       = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ST = state;

  ctrl_out_dec u_dec (
    .state     (state),
    .op        (OP),
    .zf        (FR[3]),
    .pc_write  (PC_Write),
    .pc0_write (PC0_Write),
    .ir_write  (IR_Write),
    .reg_write (Reg_Write),
    .mem_write (Mem_Write),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .pc_s      (PC_s),
    .alu_op    (ALU_OP)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; counter width reduced to 4 bits so
// the wrap-around is reachable. Covers MULTICYCLE_CTRL_STEP_EN when defined.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JAL, IS_JALR;
  logic [3:0] OP, FR;
  logic       step;
  logic       PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write, rs2_imm_s;
  logic [1:0] w_data_s, PC_s;
  logic [3:0] ALU_OP, ST;
  logic [3:0] retire_cnt;
  logic [13:0] ctl;

  int vectors = 0;
  int errors  = 0;

  // {PC_Write,PC0_Write,IR_Write, Reg_Write,Mem_Write,rs2_imm_s, w_data_s, PC_s, ALU_OP}
  localparam logic [13:0] C_NONE  = 14'b000_000_00_00_0000;
  localparam logic [13:0] C_IF    = 14'b111_000_00_00_0000;
  localparam logic [13:0] C_WB    = 14'b000_100_00_00_0000;
  localparam logic [13:0] C_MA    = 14'b000_001_00_00_0000;
  localparam logic [13:0] C_WBLW  = 14'b000_100_10_00_0000;
  localparam logic [13:0] C_SW    = 14'b000_010_00_00_0000;
  localparam logic [13:0] C_LUI   = 14'b000_100_01_00_0000;
  localparam logic [13:0] C_BEQT  = 14'b100_000_00_01_1000;
  localparam logic [13:0] C_BEQN  = 14'b000_000_00_01_1000;
  localparam logic [13:0] C_JAL   = 14'b100_100_11_01_0000;
  localparam logic [13:0] C_JALR  = 14'b100_101_11_10_0000;

  assign ctl = {PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write, rs2_imm_s,
                w_data_s, PC_s, ALU_OP};

  multicycle_ctrl #(.W_CNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .IS_R       (IS_R),
    .IS_IMM     (IS_IMM),
    .IS_LUI     (IS_LUI),
    .IS_LW      (IS_LW),
    .IS_SW      (IS_SW),
    .IS_BEQ     (IS_BEQ),
    .IS_JAL     (IS_JAL),
    .IS_JALR    (IS_JALR),
    .OP         (OP),
    .FR         (FR),
`ifdef MULTICYCLE_CTRL_STEP_EN
    .step       (step),
`endif
    .PC_Write   (PC_Write),
    .PC0_Write  (PC0_Write),
    .IR_Write   (IR_Write),
    .Reg_Write  (Reg_Write),
    .Mem_Write  (Mem_Write),
    .rs2_imm_s  (rs2_imm_s),
    .w_data_s   (w_data_s),
    .PC_s       (PC_s),
    .ALU_OP     (ALU_OP),
    .ST         (ST),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input string tag, input logic [3:0] est, input logic [13:0] ectl);
    tick();
    check({tag, ".st"}, {12'd0, ST}, {12'd0, est});
    check({tag, ".ctl"}, {2'd0, ctl}, {2'd0, ectl});
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] exp);
    check({tag, ".cnt"}, {12'd0, retire_cnt}, {12'd0, exp});
  endtask

  task automatic clear_is();
    {IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JAL, IS_JALR} = 8'd0;
  endtask

  initial begin
    rst = 1'b0; step = 1'b0; OP = 4'd0; FR = 4'd0;
    clear_is();
    tick(); tick();
    check("rst.st", {12'd0, ST}, 16'd0);
    check("rst.ctl", {2'd0, ctl}, 16'd0);
    check_cnt("rst", 4'd0);
    rst = 1'b1;

`ifdef MULTICYCLE_CTRL_STEP_EN
    IS_R = 1'b1; OP = 4'b0111;
    step_chk("hold0", 4'd0, C_NONE);
    step_chk("hold1", 4'd0, C_NONE);
    step = 1'b1;
    step_chk("s1.if", 4'd1, C_IF);
    step_chk("s1.id", 4'd2, C_NONE);
    step_chk("s1.ex", 4'd3, 14'b000_000_00_00_0111);
    step_chk("s1.wb", 4'd5, C_WB);
    step = 1'b0;
    step_chk("s1.idle", 4'd0, C_NONE);
    check_cnt("s1", 4'd1);
    step_chk("s1.hold", 4'd0, C_NONE);
    check_cnt("s1.hold", 4'd1);
    step = 1'b1;
    clear_is();
    step_chk("s2.if", 4'd1, C_IF);
    step = 1'b0;
    step_chk("s2.id", 4'd2, C_NONE);
    step_chk("s2.idle", 4'd0, C_NONE);
    check_cnt("s2", 4'd2);
`else
    step_chk("if0", 4'd1, C_IF);
    check_cnt("if0", 4'd0);

    IS_R = 1'b1; OP = 4'b0111;
    step_chk("r.id", 4'd2, C_NONE);
    step_chk("r.ex", 4'd3, 14'b000_000_00_00_0111);
    check_cnt("r.ex", 4'd0);
    step_chk("r.wb", 4'd5, C_WB);
    step_chk("r.if", 4'd1, C_IF);
    check_cnt("r", 4'd1);

    clear_is(); IS_LW = 1'b1;
    step_chk("lw.id", 4'd2, C_NONE);
    step_chk("lw.ma", 4'd7, C_MA);
    step_chk("lw.mem", 4'd8, C_NONE);
    step_chk("lw.wb", 4'd9, C_WBLW);
    step_chk("lw.if", 4'd1, C_IF);
    check_cnt("lw", 4'd2);

    clear_is(); IS_SW = 1'b1;
    step_chk("sw.id", 4'd2, C_NONE);
    step_chk("sw.ma", 4'd7, C_MA);
    step_chk("sw.mem", 4'd10, C_SW);
    step_chk("sw.if", 4'd1, C_IF);
    check_cnt("sw", 4'd3);

    clear_is(); IS_BEQ = 1'b1; FR = 4'b1000;
    step_chk("beqt.id", 4'd2, C_NONE);
    step_chk("beqt.ex", 4'd11, C_BEQT);
    step_chk("beqt.if", 4'd1, C_IF);
    check_cnt("beqt", 4'd4);

    FR = 4'b0000;
    step_chk("beqn.id", 4'd2, C_NONE);
    step_chk("beqn.ex", 4'd11, C_BEQN);
    step_chk("beqn.if", 4'd1, C_IF);
    check_cnt("beqn", 4'd5);

    clear_is(); IS_JAL = 1'b1;
    step_chk("jal.id", 4'd2, C_NONE);
    step_chk("jal.ex", 4'd12, C_JAL);
    step_chk("jal.if", 4'd1, C_IF);
    check_cnt("jal", 4'd6);

    clear_is(); IS_JALR = 1'b1; OP = 4'b0101;
    step_chk("jalr.id", 4'd2, C_NONE);
    step_chk("jalr.ex", 4'd13, C_JALR);
    step_chk("jalr.if", 4'd1, C_IF);
    check_cnt("jalr", 4'd7);

    clear_is(); IS_IMM = 1'b1; OP = 4'b0011;
    step_chk("imm.id", 4'd2, C_NONE);
    step_chk("imm.ex", 4'd4, 14'b000_001_00_00_0011);
    step_chk("imm.wb", 4'd5, C_WB);
    step_chk("imm.if", 4'd1, C_IF);
    check_cnt("imm", 4'd8);

    clear_is(); IS_LUI = 1'b1;
    step_chk("lui.id", 4'd2, C_NONE);
    step_chk("lui.ex", 4'd6, C_LUI);
    step_chk("lui.if", 4'd1, C_IF);
    check_cnt("lui", 4'd9);

    clear_is(); IS_R = 1'b1; IS_LW = 1'b1; OP = 4'b0001;
    step_chk("pri1.id", 4'd2, C_NONE);
    step_chk("pri1.ex", 4'd3, 14'b000_000_00_00_0001);
    step_chk("pri1.wb", 4'd5, C_WB);
    step_chk("pri1.if", 4'd1, C_IF);

    clear_is(); IS_SW = 1'b1; IS_BEQ = 1'b1; IS_JAL = 1'b1;
    step_chk("pri2.id", 4'd2, C_NONE);
    step_chk("pri2.ma", 4'd7, C_MA);
    step_chk("pri2.mem", 4'd10, C_SW);
    step_chk("pri2.if", 4'd1, C_IF);
    check_cnt("pri", 4'd11);

    clear_is();
    step_chk("nop.id", 4'd2, C_NONE);
    step_chk("nop.if", 4'd1, C_IF);
    check_cnt("nop", 4'd12);

    IS_LW = 1'b1;
    step_chk("ar.id", 4'd2, C_NONE);
    step_chk("ar.ma", 4'd7, C_MA);
    #2 rst = 1'b0;
    #1;
    check("ar.st", {12'd0, ST}, 16'd0);
    check("ar.ctl", {2'd0, ctl}, 16'd0);
    check_cnt("ar", 4'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_is();
    step_chk("ar.if", 4'd1, C_IF);

    force dut.state = state_t'(4'd15);
    #1 release dut.state;
    check("ill.st", {12'd0, ST}, 16'd15);
    check("ill.ctl", {2'd0, ctl}, 16'd0);
    step_chk("ill.rec", 4'd0, C_NONE);
    step_chk("ill.if", 4'd1, C_IF);
    check_cnt("ill", 4'd0);

    for (int i = 0; i < 15; i++) begin
      tick(); tick();
    end
    check("wrap.st", {12'd0, ST}, 16'd1);
    check_cnt("pre_wrap", 4'd15);
    tick(); tick();
    check_cnt("wrap", 4'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
